hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard and forwarding controller for the 5-stage CPU. It watches register indices and control bits in ID, EX, MEM and WB, and drives three things:
- stall enables for the IF and IF/ID registers;
- the `CLR` (bubble) input of the ID/EX register;
- forwarding selects for the ID-stage branch comparator and the EX-stage ALU operands.

It also tracks the multi-cycle mult/div unit so that later HI/LO users stall until the result is ready, and it keeps a saturating stall-cycle counter.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after a mult issues.
- `DIV_CYCLES`, default 10: busy cycles after a div issues.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rsD`, `rtD`  in  5 each  source registers of the instruction in ID.
- `branchD`  in  1  ID instruction is a branch compared in ID; uses rs and rt.
- `jrD`  in  1  ID instruction is jr; uses rs only.
- `mdUseD`  in  1  ID instruction is mult, div, mfhi or mflo.
- `mdStartD`  in  1  ID instruction is mult or div.
- `mdDivD`  in  1  with `mdStartD`: 1 = div, 0 = mult.
- `rsE`, `rtE`, `writeRegE`  in  5 each  source and destination registers in EX.
- `RegWriteE`, `MemtoRegE`  in  1 each  EX control bits.
- `writeRegM`  in  5  MEM destination register.
- `RegWriteM`, `MemtoRegM`  in  1 each  MEM control bits.
- `writeRegW`  in  5  WB destination register.
- `RegWriteW`  in  1  WB control bit.
- `StallF`, `StallD`  out  1 each  hold the PC and the IF/ID register.
- `FlushE`  out  1  drives ID/EX `CLR`.
- `ForwardAD`, `ForwardBD`  out  1 each  ID comparator operand takes the MEM ALU result.
- `ForwardAE`, `ForwardBE`  out  2 each  ALU operand source: 00 = register file, 10 = MEM, 01 = WB.
- `mdBusy`  out  1  mult/div result not yet available.
- `stallCount`  out  32  total stall cycles since reset, saturating.

## Operation
- Register 0 never causes a hazard and is never forwarded. Every index comparison is qualified by `idx != 0`.
- Load-use stall (`lwstall`): `MemtoRegE` is set and `writeRegE` equals `rsD` or `rtD`.
- Branch stall (`brstall`), for `branchD` (rs and rt) or `jrD` (rs only). It asserts when either:
  - `RegWriteE` is set and `writeRegE` matches a used source; or
  - `MemtoRegM` is set and `writeRegM` matches a used source.
- Mult/div stall (`mdstall`): `mdUseD && mdBusy`.
- `stall = lwstall | brstall | mdstall`. `StallF = StallD = FlushE = stall`.
- EX forwarding for operand A (B is identical using `rtE`):
  - 10 if `RegWriteM` is set and `writeRegM == rsE`;
  - otherwise 01 if `RegWriteW` is set and `writeRegW == rsE`;
  - otherwise 00.
  - MEM has priority over WB.
- ID forwarding: `ForwardAD = RegWriteM && writeRegM == rsD`. `ForwardBD` is the same using `rtD`.
- Mult/div counter (`mdCount`):
  - Issue happens when `mdStartD && !stall`. At that clock edge `mdCount` loads `DIV_CYCLES` if `mdDivD`, otherwise `MULT_CYCLES`.
  - With no issue and `mdCount > 0`, it decrements by 1. At 0 it holds.
  - `mdBusy = (mdCount != 0)`.
  - A mult/div arriving in ID while busy stalls, because `mdUseD` covers it. It therefore never reloads a live count.
- `stallCount` increments by 1 on each edge where `stall` is 1. It saturates at `32'hFFFFFFFF`.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and the registered `mdCount`; there is no added latency.
- After the issue edge, `mdBusy` is high for exactly N cycles (N = `MULT_CYCLES` or `DIV_CYCLES`). It falls on the Nth following edge.
- A dependent `mflo` in ID therefore stalls N cycles and then proceeds.
- A load-use stall lasts exactly 1 cycle when EX holds the load.
- Branch stall timing:
  - 1 cycle if the producer is an ALU instruction in EX;
  - 2 cycles if the producer is a load in EX (EX stall, then MEM stall).
- Simultaneous stall sources OR together; the count still increments by only 1 per cycle.
- Reset behaviour:
  - Asserting `reset` at any time, including mid-busy, clears `mdCount` and `stallCount` to 0 at once, so `mdBusy` = 0.
  - All combinational outputs follow their inputs during reset. With all-zero inputs every output is 0.

## Structure
- The shared package `hazard_pkg` holds:
  - `FWD_RF = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`;
  - default `MULT_CYCLES` and `DIV_CYCLES` values.
- One sub-module, `md_busy_counter`:
  - inputs: `clk`, `reset`, `issue`, `isDiv`;
  - output: `busy`;
  - holds the load/decrement logic.
- The top level holds the hazard comparators, forwarding muxing and `stallCount`.

## Test plan
- Load-use: `MemtoRegE` = 1, `writeRegE` = 8, `rsD` = 8 → `StallF` = `StallD` = `FlushE` = 1 for one cycle. With `writeRegE` = 0 and `rsD` = 0 → no stall.
- EX forwarding priority: `RegWriteM` = 1, `writeRegM` = 9, `RegWriteW` = 1, `writeRegW` = 9, `rsE` = 9 → `ForwardAE` = 10. Clear `RegWriteM` → 01. Set `rsE` = 0 → 00.
- Branch: `branchD` = 1, `rtD` = 4.
  - `RegWriteE` = 1, `writeRegE` = 4 → stall.
  - Same producer moved to MEM with `MemtoRegM` = 0 → no stall, `ForwardBD` = 1.
- Mult/div: issue div (`mdStartD` = 1, `mdDivD` = 1), then present `mdUseD` = 1 → `mdBusy` and stall high for exactly 10 cycles, then both 0. A mult gives exactly 5 cycles.
- Reset mid-busy: assert `reset` 3 cycles after a div issues → `mdBusy` = 0 and `stallCount` = 0 immediately, without waiting for a clock edge.
- Counter: hold `lwstall` for 7 cycles → `stallCount` = 7. Force the count to `32'hFFFFFFFF` → it stays there on further stalls.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and index/forwarding helpers for the pipeline hazard unit.
package hazard_pkg;

   // ALU operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Default latencies of the multi-cycle mult/div unit
   localparam int MULT_CYCLES_DEFAULT = 5;
   localparam int DIV_CYCLES_DEFAULT  = 10;

   // A producer matches a consumer only for a nonzero register index;
   // $zero is hardwired, so it never carries a dependency.
   function automatic logic idx_hit(input logic [4:0] producer,
                                    input logic [4:0] consumer);
      return (producer != 5'd0) && (producer == consumer);
   endfunction

   // EX operand source: the younger MEM result wins over WB.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       reg_write_m,
                                          input logic [4:0] write_reg_m,
                                          input logic       reg_write_w,
                                          input logic [4:0] write_reg_w);
      if (reg_write_m && idx_hit(write_reg_m, src))
         return FWD_MEM;
      else if (reg_write_w && idx_hit(write_reg_w, src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-stage register indices and control bits seen by the hazard unit,
// plus the stall/flush/forward controls it returns to the datapath.
interface hazard_unit_if;
   import hazard_pkg::*;

   // ID stage
   logic [4:0]  rsD;
   logic [4:0]  rtD;
   logic        branchD;
   logic        jrD;
   logic        mdUseD;
   logic        mdStartD;
   logic        mdDivD;
   // EX stage
   logic [4:0]  rsE;
   logic [4:0]  rtE;
   logic [4:0]  writeRegE;
   logic        RegWriteE;
   logic        MemtoRegE;
   // MEM stage
   logic [4:0]  writeRegM;
   logic        RegWriteM;
   logic        MemtoRegM;
   // WB stage
   logic [4:0]  writeRegW;
   logic        RegWriteW;
   // Controls back to the pipeline
   logic        StallF;
   logic        StallD;
   logic        FlushE;
   logic        ForwardAD;
   logic        ForwardBD;
   logic [1:0]  ForwardAE;
   logic [1:0]  ForwardBE;
   logic        mdBusy;
   logic [31:0] stallCount;

   // Pipeline side: drives stage information, receives controls
   modport master (
      output rsD, rtD, branchD, jrD, mdUseD, mdStartD, mdDivD,
             rsE, rtE, writeRegE, RegWriteE, MemtoRegE,
             writeRegM, RegWriteM, MemtoRegM,
             writeRegW, RegWriteW,
      input  StallF, StallD, FlushE, ForwardAD, ForwardBD,
             ForwardAE, ForwardBE, mdBusy, stallCount
   );

   // Hazard unit side
   modport slave (
      input  rsD, rtD, branchD, jrD, mdUseD, mdStartD, mdDivD,
             rsE, rtE, writeRegE, RegWriteE, MemtoRegE,
             writeRegM, RegWriteM, MemtoRegM,
             writeRegW, RegWriteW,
      output StallF, StallD, FlushE, ForwardAD, ForwardBD,
             ForwardAE, ForwardBE, mdBusy, stallCount
   );

endinterface

// File: rtl/md_busy_counter.sv
// Tracks the remaining latency of the multi-cycle mult/div unit.
// Busy stays high for exactly N cycles after the issue edge.
module md_busy_counter
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic issue,
   input  logic isDiv,
   output logic busy
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] r_count;

   // Load the op latency on issue, otherwise count down to zero and hold.
   // Issue is only possible while idle, so a live count is never reloaded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_count <= '0;
      else if (issue)
         r_count <= isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      else if (r_count != '0)
         r_count <= r_count - CW'(1);
   end

   assign busy = (r_count != '0);

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline:
// load-use, branch-operand and mult/div stalls, ID/EX forwarding selects,
// and a saturating count of stalled cycles.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave hz
);

   logic        w_lw_stall;
   logic        w_br_stall;
   logic        w_md_stall;
   logic        w_stall;
   logic        w_use_rs;
   logic        w_use_rt;
   logic        w_rs_pending;
   logic        w_rt_pending;
   logic        w_md_issue;
   logic        w_md_busy;
   logic [31:0] r_stall_count;

   // A load in EX cannot forward until it reaches WB: hold ID one cycle.
   assign w_lw_stall = hz.MemtoRegE &&
                       (idx_hit(hz.writeRegE, hz.rsD) || idx_hit(hz.writeRegE, hz.rtD));

   // The ID comparator only sees the MEM ALU result, so an EX producer or a
   // load still in MEM must be waited out.
   assign w_use_rs     = hz.branchD || hz.jrD;
   assign w_use_rt     = hz.branchD;
   assign w_rs_pending = (hz.RegWriteE && idx_hit(hz.writeRegE, hz.rsD)) ||
                         (hz.MemtoRegM && idx_hit(hz.writeRegM, hz.rsD));
   assign w_rt_pending = (hz.RegWriteE && idx_hit(hz.writeRegE, hz.rtD)) ||
                         (hz.MemtoRegM && idx_hit(hz.writeRegM, hz.rtD));
   assign w_br_stall   = (w_use_rs && w_rs_pending) || (w_use_rt && w_rt_pending);

   // HI/LO users, including a new mult/div, wait for the unit to drain.
   assign w_md_stall = hz.mdUseD && w_md_busy;

   assign w_stall   = w_lw_stall || w_br_stall || w_md_stall;
   assign hz.StallF = w_stall;
   assign hz.StallD = w_stall;
   assign hz.FlushE = w_stall;

   // Forwarding selects
   assign hz.ForwardAD = hz.RegWriteM && idx_hit(hz.writeRegM, hz.rsD);
   assign hz.ForwardBD = hz.RegWriteM && idx_hit(hz.writeRegM, hz.rtD);
   assign hz.ForwardAE = fwd_sel(hz.rsE, hz.RegWriteM, hz.writeRegM, hz.RegWriteW, hz.writeRegW);
   assign hz.ForwardBE = fwd_sel(hz.rtE, hz.RegWriteM, hz.writeRegM, hz.RegWriteW, hz.writeRegW);

   // A mult/div leaves ID only when nothing holds the pipeline.
   assign w_md_issue = hz.mdStartD && !w_stall;

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy (
      .clk   (clk),
      .reset (reset),
      .issue (w_md_issue),
      .isDiv (hz.mdDivD),
      .busy  (w_md_busy)
   );

   assign hz.mdBusy = w_md_busy;

   // Count stalled cycles, one per edge regardless of how many sources fire,
   // sticking at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_stall_count <= '0;
      else if (w_stall && (r_stall_count != '1))
         r_stall_count <= r_stall_count + 32'd1;
   end

   assign hz.stallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: the driver applies one vector per cycle and
// queues its hand-computed outputs; the monitor checks them at the falling edge.
module tb_hazard_unit;
   import hazard_pkg::*;

   typedef struct {
      string       name;
      logic        stall;
      logic        fad;
      logic        fbd;
      logic [1:0]  fae;
      logic [1:0]  fbe;
      logic        busy;
      logic [31:0] cnt;
   } exp_t;

   logic  clk;
   logic  reset;
   exp_t  q[$];
   int    n_vec;
   int    n_bad;

   hazard_unit_if hz();

   hazard_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr_in();
      hz.rsD = 5'd0; hz.rtD = 5'd0; hz.branchD = 1'b0; hz.jrD = 1'b0;
      hz.mdUseD = 1'b0; hz.mdStartD = 1'b0; hz.mdDivD = 1'b0;
      hz.rsE = 5'd0; hz.rtE = 5'd0; hz.writeRegE = 5'd0;
      hz.RegWriteE = 1'b0; hz.MemtoRegE = 1'b0;
      hz.writeRegM = 5'd0; hz.RegWriteM = 1'b0; hz.MemtoRegM = 1'b0;
      hz.writeRegW = 5'd0; hz.RegWriteW = 1'b0;
   endtask

   task automatic put(input string n, input logic st, input logic fad, input logic fbd,
                      input logic [1:0] fae, input logic [1:0] fbe,
                      input logic busy, input logic [31:0] cnt);
      exp_t e;
      e.name = n; e.stall = st; e.fad = fad; e.fbd = fbd;
      e.fae = fae; e.fbe = fbe; e.busy = busy; e.cnt = cnt;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
      end
   endtask

   // Monitor: one queued vector is checked per falling edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         chk(e.name, "StallF",     32'(hz.StallF),    32'(e.stall));
         chk(e.name, "StallD",     32'(hz.StallD),    32'(e.stall));
         chk(e.name, "FlushE",     32'(hz.FlushE),    32'(e.stall));
         chk(e.name, "ForwardAD",  32'(hz.ForwardAD), 32'(e.fad));
         chk(e.name, "ForwardBD",  32'(hz.ForwardBD), 32'(e.fbd));
         chk(e.name, "ForwardAE",  32'(hz.ForwardAE), 32'(e.fae));
         chk(e.name, "ForwardBE",  32'(hz.ForwardBE), 32'(e.fbe));
         chk(e.name, "mdBusy",     32'(hz.mdBusy),    32'(e.busy));
         chk(e.name, "stallCount", hz.stallCount,     e.cnt);
      end
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      clr_in();
      step();

      // All-zero inputs under reset
      put("in_reset", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd0); step();
      reset = 1'b0;
      put("idle", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd0); step();

      // Load-use
      clr_in(); hz.MemtoRegE = 1; hz.writeRegE = 5'd8; hz.rsD = 5'd8;
      put("lw_use", 1, 0, 0, FWD_RF, FWD_RF, 0, 32'd0); step();
      clr_in(); hz.MemtoRegE = 1; hz.RegWriteM = 1;
      put("lw_r0", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd1); step();

      // EX forwarding priority
      clr_in(); hz.RegWriteM = 1; hz.writeRegM = 5'd9; hz.RegWriteW = 1; hz.writeRegW = 5'd9;
      hz.rsE = 5'd9;
      put("fwd_mem", 0, 0, 0, FWD_MEM, FWD_RF, 0, 32'd1); step();
      hz.RegWriteM = 0; hz.rtE = 5'd9;
      put("fwd_wb", 0, 0, 0, FWD_WB, FWD_WB, 0, 32'd1); step();
      hz.rsE = 5'd0;
      put("fwd_rf", 0, 0, 0, FWD_RF, FWD_WB, 0, 32'd1); step();

      // Branch operand hazards
      clr_in(); hz.branchD = 1; hz.rtD = 5'd4; hz.RegWriteE = 1; hz.writeRegE = 5'd4;
      put("br_ex", 1, 0, 0, FWD_RF, FWD_RF, 0, 32'd1); step();
      clr_in(); hz.branchD = 1; hz.rtD = 5'd4; hz.RegWriteM = 1; hz.writeRegM = 5'd4;
      put("br_mem_alu", 0, 0, 1, FWD_RF, FWD_RF, 0, 32'd2); step();
      hz.MemtoRegM = 1;
      put("br_mem_ld", 1, 0, 1, FWD_RF, FWD_RF, 0, 32'd2); step();
      clr_in(); hz.jrD = 1; hz.rtD = 5'd4; hz.RegWriteE = 1; hz.writeRegE = 5'd4;
      put("jr_rt", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd3); step();
      hz.rsD = 5'd4;
      put("jr_rs", 1, 0, 0, FWD_RF, FWD_RF, 0, 32'd3); step();

      // Div: 10 busy cycles
      clr_in(); hz.mdStartD = 1; hz.mdDivD = 1; hz.mdUseD = 1;
      put("div_issue", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd4); step();
      for (int i = 0; i < 10; i++) begin
         clr_in(); hz.mdUseD = 1;
         put($sformatf("div_busy%0d", i), 1, 0, 0, FWD_RF, FWD_RF, 1, 32'(4 + i)); step();
      end
      clr_in(); hz.mdUseD = 1;
      put("div_done", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd14); step();

      // Mult: 5 busy cycles; a second mult waiting in ID must not reload
      clr_in(); hz.mdStartD = 1; hz.mdUseD = 1;
      put("mul_issue", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd14); step();
      for (int i = 0; i < 5; i++) begin
         clr_in(); hz.mdStartD = 1; hz.mdUseD = 1;
         put($sformatf("mul_busy%0d", i), 1, 0, 0, FWD_RF, FWD_RF, 1, 32'(14 + i)); step();
      end
      clr_in(); hz.mdUseD = 1;
      put("mul_done", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd19); step();

      // Reset while a div is in flight
      clr_in(); hz.mdStartD = 1; hz.mdDivD = 1;
      put("rdiv_issue", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd19); step();
      clr_in();
      put("rdiv_b1", 0, 0, 0, FWD_RF, FWD_RF, 1, 32'd19); step();
      put("rdiv_b2", 0, 0, 0, FWD_RF, FWD_RF, 1, 32'd19); step();
      reset = 1'b1;
      put("rst_mid", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd0); step();
      reset = 1'b0;
      put("rst_rel", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd0); step();

      // Seven load-use cycles
      for (int i = 0; i < 7; i++) begin
         clr_in(); hz.MemtoRegE = 1; hz.writeRegE = 5'd5; hz.rtD = 5'd5;
         put($sformatf("lw_hold%0d", i), 1, 0, 0, FWD_RF, FWD_RF, 0, 32'(i)); step();
      end
      clr_in();
      put("cnt7", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'd7); step();

      // Saturation
      force dut.r_stall_count = 32'hFFFF_FFFE;
      #1;
      release dut.r_stall_count;
      put("sat_load", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'hFFFF_FFFE); step();
      for (int i = 0; i < 3; i++) begin
         clr_in(); hz.MemtoRegE = 1; hz.writeRegE = 5'd5; hz.rsD = 5'd5;
         put($sformatf("sat%0d", i), 1, 0, 0, FWD_RF, FWD_RF, 0,
             (i == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF); step();
      end
      clr_in();
      put("sat_end", 0, 0, 0, FWD_RF, FWD_RF, 0, 32'hFFFF_FFFF); step();

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
